fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the tensor-core front end.
- Owns the fetch PC and drives the instruction-memory read port.
- Consults the target-buffer predictor (tbp) on every completed fetch to choose the next PC.
- Buffers fetched instructions in a small flushable queue feeding decode.
- Applies redirects from branch resolution, including requests whose miss is still in flight.

---
 rtl/datapath_types.sv | 21 ++
 rtl/fetch_queue.sv | 58 +++++
 rtl/fetch_ctrl.sv | 174 +++++++++++++++++
 tb/tb_fetch_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_types.sv
// Shared types for the instruction-fetch front end: FSM state encoding,
// fetch-queue entry layout and the sequential PC increment.
package datapath_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    MISS    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  localparam int PC_INC = 4;

  // Default entry layout for 32-bit PC / 32-bit instruction builds.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } fetchq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Flushable FIFO between fetch and decode. Entry type is a type parameter so
// the top can pass an entry struct sized to its own PC/instruction widths.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module fetch_queue
  import datapath_types::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetchq_entry_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  input  logic                     flush,
  output entry_t                   head,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & (count != '0);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; flush empties the queue in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  // Entry storage; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives the imem read port,
// follows the target-buffer predictor and feeds decode through fetch_queue.
// Optional build macro FETCH_PERF_EN adds saturating performance counters
// (miss cycles, redirects, dropped responses).
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | not fetching; redirects still load pc
// FETCH   | issuing pc to imem whenever the queue has room
// MISS    | request for req_addr outstanding, address held until ihit
// DISCARD | outstanding request was overtaken by a redirect; drop its data
module fetch_ctrl
  import datapath_types::*;
#(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter int              FQ_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               en,
  output logic               imem_ren,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ihit,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    tbp_pc,
  input  logic               tbp_taken,
  input  logic [PC_W-1:0]    tbp_target,
  input  logic               redir_valid,
  input  logic [PC_W-1:0]    redir_pc,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               out_pred,
  input  logic               out_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_miss_cyc,
  output logic [31:0]        perf_redir,
  output logic [31:0]        perf_discard
`endif
);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_FETCH   = FETCH;
  localparam logic [1:0] S_MISS    = MISS;
  localparam logic [1:0] S_DISCARD = DISCARD;
  localparam int         CW        = $clog2(FQ_DEPTH) + 1;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               pred;
  } q_entry_t;

  logic [1:0]      state, state_nx;
  logic [PC_W-1:0] pc, pc_nx;
  logic [PC_W-1:0] req_addr, req_nx;
  logic [PC_W-1:0] pc_seq;
  logic            in_miss;
  logic            hit;
  logic            q_push;
  logic            q_pop;
  logic            q_full;
  logic [CW-1:0]   q_count;
  q_entry_t        q_in;
  q_entry_t        q_head;

  assign in_miss   = (state == S_MISS) || (state == S_DISCARD);
  assign imem_ren  = (state == S_FETCH) ? ~q_full : in_miss;
  assign imem_addr = in_miss ? req_addr : pc;
  assign tbp_pc    = imem_addr;
  assign hit       = imem_ren & imem_ihit;
  assign pc_seq    = tbp_taken ? tbp_target : imem_addr + PC_W'(PC_INC);

  // A response is kept only when it belongs to the current path.
  assign q_push = hit & ~redir_valid & ((state == S_FETCH) || (state == S_MISS));
  assign q_pop  = out_valid & out_ready;
  assign q_in   = '{pc: imem_addr, instr: imem_rdata, pred: tbp_taken};

  // Next state / next pc; a redirect overrides everything else.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    req_nx   = req_addr;
    if (redir_valid) begin
      pc_nx = redir_pc;
      unique case (state)
        S_IDLE:  state_nx = en ? S_FETCH : S_IDLE;
        S_FETCH: state_nx = S_FETCH;
        default: state_nx = hit ? S_FETCH : S_DISCARD;
      endcase
    end else begin
      unique case (state)
        S_IDLE: begin
          if (en) state_nx = S_FETCH;
        end
        S_FETCH: begin
          if (hit) begin
            pc_nx = pc_seq;
            if (!en) state_nx = S_IDLE;
          end else if (imem_ren) begin
            req_nx   = pc;
            state_nx = S_MISS;
          end else if (!en) begin
            state_nx = S_IDLE;
          end
        end
        S_MISS: begin
          if (hit) begin
            pc_nx    = pc_seq;
            state_nx = en ? S_FETCH : S_IDLE;
          end
        end
        default: begin
          if (hit) state_nx = S_FETCH;
        end
      endcase
    end
  end

  // State, pc and held request address registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      req_addr <= req_nx;
    end
  end

  fetch_queue #(
    .DEPTH   (FQ_DEPTH),
    .entry_t (q_entry_t)
  ) u_queue (
    .clk       (CLK),
    .rst_n     (nRST),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .flush     (redir_valid),
    .head      (q_head),
    .full      (q_full),
    .count     (q_count)
  );

  assign out_valid = (q_count != '0);
  assign out_instr = q_head.instr;
  assign out_pc    = q_head.pc;
  assign out_pred  = q_head.pred;

`ifdef FETCH_PERF_EN
  logic dropped;
  assign dropped = hit & (redir_valid | (state == S_DISCARD));

  // Saturating event counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_miss_cyc <= '0;
      perf_redir    <= '0;
      perf_discard  <= '0;
    end else begin
      if (in_miss && perf_miss_cyc != '1)    perf_miss_cyc <= perf_miss_cyc + 32'd1;
      if (redir_valid && perf_redir != '1)   perf_redir    <= perf_redir + 32'd1;
      if (dropped && perf_discard != '1)     perf_discard  <= perf_discard + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a table of fill/drain vectors, hand-written
// miss/redirect/reset sequences, then random traffic against a queue-based
// reference model.
module tb_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        en;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic        imem_ihit;
  logic [31:0] imem_rdata;
  logic [31:0] tbp_pc;
  logic        tbp_taken;
  logic [31:0] tbp_target;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_pred;
  logic        out_ready;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_miss_cyc, perf_redir, perf_discard;
`endif

  int tests = 0;
  int fails = 0;

  logic        rnd_mode = 1'b0;
  logic        pred_on = 1'b0;
  logic        man_taken = 1'b0;
  logic [31:0] man_target = '0;

  always #5 CLK = ~CLK;

  fetch_ctrl dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .en          (en),
    .imem_ren    (imem_ren),
    .imem_addr   (imem_addr),
    .imem_ihit   (imem_ihit),
    .imem_rdata  (imem_rdata),
    .tbp_pc      (tbp_pc),
    .tbp_taken   (tbp_taken),
    .tbp_target  (tbp_target),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_pred    (out_pred),
    .out_ready   (out_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_miss_cyc (perf_miss_cyc),
    .perf_redir    (perf_redir),
    .perf_discard  (perf_discard)
`endif
  );

  function automatic logic [31:0] data_fn(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic pred_fn(input logic on, input logic [31:0] a);
    return on & (a[4] ^ a[7]);
  endfunction

  function automatic logic [31:0] tgt_fn(input logic [31:0] a);
    return ((a + 32'h40) ^ 32'h0000_0100) & 32'hFFFF_FFFC;
  endfunction

  // Instruction memory and predictor stand-ins.
  always_comb begin
    imem_rdata = data_fn(imem_addr);
    tbp_taken  = rnd_mode ? pred_fn(pred_on, tbp_pc) : man_taken;
    tbp_target = rnd_mode ? tgt_fn(tbp_pc) : man_target;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    en = 0; imem_ihit = 0; out_ready = 0; redir_valid = 0; redir_pc = '0;
    man_taken = 0; man_target = '0; rnd_mode = 0; pred_on = 0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  // Drive one cycle's inputs and advance to the next sampling point.
  task automatic cyc(input logic e, input logic h, input logic r, input logic rv,
                     input logic [31:0] rp, input logic tk, input logic [31:0] tg);
    en = e; imem_ihit = h; out_ready = r; redir_valid = rv; redir_pc = rp;
    man_taken = tk; man_target = tg;
    @(negedge CLK);
  endtask

  typedef struct {
    logic        en, ihit, ready;
    logic        exp_ren;
    logic [31:0] exp_addr;
    logic        exp_ov;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } ent_t;

  vec_t tbl [11];

  // Reference model state (transaction view: pending request + queue).
  logic        m_active, m_pend, m_drop;
  logic [31:0] m_pc, m_req;
  ent_t        mq[$];

  initial begin
    tbl[0]  = '{1, 1, 0, 0, 32'h00, 0, 32'h00};
    tbl[1]  = '{1, 1, 0, 1, 32'h00, 0, 32'h00};
    tbl[2]  = '{1, 1, 0, 1, 32'h04, 1, 32'h00};
    tbl[3]  = '{1, 1, 0, 1, 32'h08, 1, 32'h00};
    tbl[4]  = '{1, 1, 0, 1, 32'h0C, 1, 32'h00};
    tbl[5]  = '{1, 1, 1, 0, 32'h10, 1, 32'h00};
    tbl[6]  = '{0, 1, 1, 1, 32'h10, 1, 32'h04};
    tbl[7]  = '{0, 0, 1, 0, 32'h14, 1, 32'h08};
    tbl[8]  = '{0, 0, 1, 0, 32'h14, 1, 32'h0C};
    tbl[9]  = '{0, 0, 1, 0, 32'h14, 1, 32'h10};
    tbl[10] = '{0, 0, 0, 0, 32'h14, 0, 32'h00};

    // Fill to depth, stall on full, then drain in order.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      @(negedge CLK);
      chk($sformatf("tbl%0d ren", i), {31'd0, imem_ren}, {31'd0, tbl[i].exp_ren});
      if (tbl[i].exp_ren) chk($sformatf("tbl%0d addr", i), imem_addr, tbl[i].exp_addr);
      chk($sformatf("tbl%0d out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].exp_ov});
      if (tbl[i].exp_ov) begin
        chk($sformatf("tbl%0d out_pc", i), out_pc, tbl[i].exp_pc);
        chk($sformatf("tbl%0d out_instr", i), out_instr, data_fn(tbl[i].exp_pc));
        chk($sformatf("tbl%0d out_pred", i), {31'd0, out_pred}, 32'd0);
      end
      en = tbl[i].en; imem_ihit = tbl[i].ihit; out_ready = tbl[i].ready;
    end

    // Three-cycle miss at 0x10.
    do_reset();
    cyc(1, 0, 1, 1, 32'h10, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("miss ren %0d", i), {31'd0, imem_ren}, 32'd1);
      chk($sformatf("miss addr %0d", i), imem_addr, 32'h10);
      cyc(1, 0, 1, 0, 0, 0, 0);
    end
    chk("miss ren 3", {31'd0, imem_ren}, 32'd1);
    chk("miss addr 3", imem_addr, 32'h10);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("miss hit out_valid", {31'd0, out_valid}, 32'd1);
    chk("miss hit out_pc", out_pc, 32'h10);
    chk("miss next addr", imem_addr, 32'h14);

    // Predicted-taken fetch at 0x8.
    do_reset();
    cyc(1, 0, 0, 1, 32'h08, 0, 0);
    chk("pred addr", imem_addr, 32'h08);
    cyc(1, 1, 0, 0, 0, 1, 32'h80);
    chk("pred out_pc", out_pc, 32'h08);
    chk("pred out_pred", {31'd0, out_pred}, 32'd1);
    chk("pred next addr", imem_addr, 32'h80);

    // Redirect during a miss on 0x20.
    do_reset();
    cyc(1, 0, 0, 1, 32'h1C, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("rmiss pre out_pc", out_pc, 32'h1C);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rmiss addr", imem_addr, 32'h20);
    cyc(1, 0, 1, 1, 32'h200, 0, 0);
    chk("rmiss flushed", {31'd0, out_valid}, 32'd0);
    chk("rmiss held addr", imem_addr, 32'h20);
    chk("rmiss held ren", {31'd0, imem_ren}, 32'd1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rmiss held addr2", imem_addr, 32'h20);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("rmiss dropped", {31'd0, out_valid}, 32'd0);
    chk("rmiss new addr", imem_addr, 32'h200);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("rmiss new out_pc", out_pc, 32'h200);

    // Redirect coincident with a hit on 0x30.
    do_reset();
    cyc(1, 0, 0, 1, 32'h2C, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("rhit addr", imem_addr, 32'h30);
    cyc(1, 1, 1, 1, 32'h100, 0, 0);
    chk("rhit out_valid", {31'd0, out_valid}, 32'd0);
    chk("rhit addr new", imem_addr, 32'h100);

    // Reset asserted mid-miss.
    do_reset();
    cyc(1, 0, 0, 1, 32'h40, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rst pre ren", {31'd0, imem_ren}, 32'd1);
    chk("rst pre addr", imem_addr, 32'h44);
    #2 nRST = 1'b0;
    #1;
    chk("rst ren", {31'd0, imem_ren}, 32'd0);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst addr", imem_addr, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    chk("rst restart addr", imem_addr, 32'h0);
    chk("rst restart ren", {31'd0, imem_ren}, 32'd1);

    // Random traffic against the reference model.
    do_reset();
    rnd_mode = 1'b1;
    m_active = 0; m_pend = 0; m_drop = 0; m_pc = '0; m_req = '0;
    mq.delete();
    for (int n = 0; n < 3000; n++) begin
      logic        e_ren, hit, e, h, r, rv, tk;
      logic [31:0] e_addr, rp, tg;
      ent_t        ent;
      @(negedge CLK);
      e_ren  = m_pend ? 1'b1 : (m_active && mq.size() < 4);
      e_addr = m_pend ? m_req : m_pc;
      chk("rnd ren", {31'd0, imem_ren}, {31'd0, e_ren});
      if (e_ren) begin
        chk("rnd addr", imem_addr, e_addr);
        chk("rnd tbp_pc", tbp_pc, e_addr);
      end
      chk("rnd out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) begin
        chk("rnd out_pc", out_pc, mq[0].pc);
        chk("rnd out_instr", out_instr, mq[0].instr);
        chk("rnd out_pred", {31'd0, out_pred}, {31'd0, mq[0].pred});
      end
      e  = ($urandom_range(0, 9) != 0);
      h  = ($urandom_range(0, 9) < 6);
      r  = ($urandom_range(0, 9) < 6);
      rv = ($urandom_range(0, 19) == 0);
      rp = $urandom & 32'h0000_FFFC;
      pred_on = $urandom_range(0, 1) != 0;
      en = e; imem_ihit = h; out_ready = r; redir_valid = rv; redir_pc = rp;
      tk  = pred_fn(pred_on, e_addr);
      tg  = tgt_fn(e_addr);
      hit = e_ren & h;
      ent = '{pc: e_addr, instr: data_fn(e_addr), pred: tk};
      if (rv) begin
        m_pc = rp;
        mq.delete();
        if (hit) begin m_active = 1; m_pend = 0; m_drop = 0; end
        else if (m_pend) m_drop = 1;
        else if (!m_active) m_active = e;
      end else begin
        if (r && mq.size() != 0) void'(mq.pop_front());
        if (m_pend) begin
          if (hit) begin
            if (!m_drop) begin
              mq.push_back(ent);
              m_pc = tk ? tg : e_addr + 32'd4;
              m_active = e;
            end else begin
              m_active = 1;
            end
            m_pend = 0; m_drop = 0;
          end
        end else if (m_active) begin
          if (hit) begin
            mq.push_back(ent);
            m_pc = tk ? tg : e_addr + 32'd4;
            m_active = e;
          end else if (e_ren) begin
            m_pend = 1; m_drop = 0; m_req = m_pc;
          end else begin
            m_active = e;
          end
        end else begin
          m_active = e;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
